// File: rtl/multdiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit:
// MULTDIVControl op codes, default latencies and FSM state encoding.
package multdiv_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Codes 9..15 fall outside every range check and behave as NONE.
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// MIPS E-stage multiply/divide unit: owns HI/LO, computes results at the start
// edge into shadow registers and commits them after a fixed busy period.
//
// Handshake: an operation is accepted on a rising edge where start=1, cancel=0,
// op is MULT/MULTU/DIV/DIVU and busy=0; busy is then high for exactly N cycles and
// HI/LO update on the edge where busy falls. start/MTHI/MTLO while busy are ignored.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd,
    output logic        state_dbg
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi_n, lo_n;
    logic               accept, commit, mt_ok;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        commit   = 1'b0;
        mt_ok    = 1'b0;
        case (state)
            ST_IDLE: begin
                mt_ok = !cancel;
                if (start && !cancel && is_arith(op)) begin
                    accept   = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    commit   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_RUN);
    assign state_dbg = state;

    // ---------------- arithmetic ----------------
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               a_neg, b_neg, b_zero;
    logic        [31:0] a_mag, b_mag, b_safe, mag_safe;
    logic        [31:0] uq_mag, ur_mag, q_s, r_s, q_u, r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of hitting signed-overflow behaviour of the / operator.
    always_comb begin
        a_neg    = a[31];
        b_neg    = b[31];
        b_zero   = (b == 32'd0);
        a_mag    = a_neg ? (32'd0 - a) : a;
        b_mag    = b_neg ? (32'd0 - b) : b;
        b_safe   = b_zero ? 32'd1 : b;
        mag_safe = b_zero ? 32'd1 : b_mag;
        uq_mag   = a_mag / mag_safe;
        ur_mag   = a_mag % mag_safe;
        q_s      = (a_neg ^ b_neg) ? (32'd0 - uq_mag) : uq_mag;
        r_s      = a_neg ? (32'd0 - ur_mag) : ur_mag;
        q_u      = a / b_safe;
        r_u      = a % b_safe;
    end

    // ---------------- counter, shadows, HI/LO ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            hi_n <= '0;
            lo_n <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (accept) begin
                cnt <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                if (is_div(op) && b_zero) begin
                    // Divide by zero: commit re-writes the current HI/LO.
                    hi_n <= hi;
                    lo_n <= lo;
                end else begin
                    case (op)
                        OP_MULT:  begin hi_n <= prod_s[63:32]; lo_n <= prod_s[31:0]; end
                        OP_MULTU: begin hi_n <= prod_u[63:32]; lo_n <= prod_u[31:0]; end
                        OP_DIV:   begin hi_n <= r_s;           lo_n <= q_s;          end
                        default:  begin hi_n <= r_u;           lo_n <= q_u;          end
                    endcase
                end
            end else if (state == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (commit) begin
                hi <= hi_n;
                lo <= lo_n;
            end else if (mt_ok && op == OP_MTHI) begin
                hi <= a;
            end else if (mt_ok && op == OP_MTLO) begin
                lo <= a;
            end
        end
    end

    always_comb begin
        rd = 32'd0;
        case (op)
            OP_MFHI: rd = hi;
            OP_MFLO: rd = lo;
            default: rd = 32'd0;
        endcase
    end

endmodule
